// File: rtl/axis_word_packer_pkg.sv
// Shared widths, lane-index type and beat-size helpers for the AXI-Stream word packer.
package axis_word_packer_pkg;

   localparam int CFG_WIDTH    = 16;
   localparam int DEF_S_WIDTH  = 32;
   localparam int DEF_M_WIDTH  = 128;

   function automatic int calc_ratio(input int s_width, input int m_width);
      return m_width / s_width;
   endfunction

   function automatic int calc_cntr_width(input int ratio);
      return (ratio > 2) ? $clog2(ratio) : 1;
   endfunction

   localparam int DEF_RATIO      = calc_ratio(DEF_S_WIDTH, DEF_M_WIDTH);
   localparam int DEF_CNTR_WIDTH = calc_cntr_width(DEF_RATIO);

   typedef logic [DEF_CNTR_WIDTH-1:0] lane_idx_t;

   // Index of the final lane of a beat: the requested size clamped to the lanes available.
   function automatic int clamp_beat_last(input int cfg_low, input int ratio);
      return (cfg_low > ratio - 1) ? ratio - 1 : cfg_low;
   endfunction

endpackage

// File: rtl/axis_word_packer_acc.sv
// Lane accumulator for the word packer: collects narrow words into lanes and flags the last lane.
// AXIS_WORD_PACKER_FLUSH_EN adds a clear input and exposes the partial word for flushing.
module axis_word_packer_acc
   import axis_word_packer_pkg::*;
#(
   parameter int S_WIDTH = 32,
   parameter int M_WIDTH = 128
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [CFG_WIDTH-1:0] cfg_data,
   input  logic [S_WIDTH-1:0]   word,
   input  logic                 accept,
`ifdef AXIS_WORD_PACKER_FLUSH_EN
   input  logic                 clear,
   output logic [M_WIDTH-1:0]   partial_word,
   output logic                 partial_valid,
`endif
   output logic [M_WIDTH-1:0]   packed_word,
   output logic                 last_lane
);

   localparam int RATIO      = calc_ratio(S_WIDTH, M_WIDTH);
   localparam int CNTR_WIDTH = calc_cntr_width(RATIO);

   logic [M_WIDTH-1:0]    acc;
   logic [CNTR_WIDTH-1:0] count;
   logic [CNTR_WIDTH-1:0] beat_last;
   logic [CNTR_WIDTH-1:0] cfg_last;
   logic [CNTR_WIDTH-1:0] eff_last;
   logic                  unused_cfg;

   assign cfg_last   = CNTR_WIDTH'(clamp_beat_last(int'(cfg_data[CNTR_WIDTH-1:0]), RATIO));
   assign unused_cfg = ^cfg_data[CFG_WIDTH-1:CNTR_WIDTH];

   // Lane 0 still sees the live configuration; later lanes use the value latched with lane 0.
   assign eff_last  = (count == '0) ? cfg_last : beat_last;
   assign last_lane = (count == eff_last);

   always_comb begin
      packed_word = acc;
      for (int i = 0; i < RATIO; i++) begin
         if (count == CNTR_WIDTH'(i)) begin
            packed_word[i*S_WIDTH +: S_WIDTH] = word;
         end
      end
   end

`ifdef AXIS_WORD_PACKER_FLUSH_EN
   assign partial_word  = acc;
   assign partial_valid = (count != '0);
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         acc       <= '0;
         count     <= '0;
         beat_last <= '0;
      end else if (accept) begin
         if (last_lane) begin
            acc   <= '0;
            count <= '0;
         end else begin
            acc   <= packed_word;
            count <= count + CNTR_WIDTH'(1);
         end
         if (count == '0) begin
            beat_last <= cfg_last;
         end
      end
`ifdef AXIS_WORD_PACKER_FLUSH_EN
      else if (clear) begin
         acc   <= '0;
         count <= '0;
      end
`endif
   end

endmodule

// File: rtl/axis_word_packer.sv
// Packs cfg_data+1 narrow AXI-Stream words (word 0 in the LSB lane) into one wide output beat.
// Define AXIS_WORD_PACKER_FLUSH_EN to add the flush input that emits a partial beat.
module axis_word_packer
   import axis_word_packer_pkg::*;
#(
   parameter int S_AXIS_TDATA_WIDTH = 32,
   parameter int M_AXIS_TDATA_WIDTH = 128
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [CFG_WIDTH-1:0]          cfg_data,
   input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
`ifdef AXIS_WORD_PACKER_FLUSH_EN
   input  logic                          flush,
`endif
   output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready
);

   logic                          running;
   logic                          last_lane;
   logic                          out_free;
   logic                          accept;
   logic                          load;
   logic                          flush_fire;
   logic [M_AXIS_TDATA_WIDTH-1:0] packed_word;

`ifdef AXIS_WORD_PACKER_FLUSH_EN
   logic [M_AXIS_TDATA_WIDTH-1:0] partial_word;
   logic                          partial_valid;
`endif

   axis_word_packer_acc #(
      .S_WIDTH (S_AXIS_TDATA_WIDTH),
      .M_WIDTH (M_AXIS_TDATA_WIDTH)
   ) u_acc (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_data      (cfg_data),
      .word          (s_axis_tdata),
      .accept        (accept),
`ifdef AXIS_WORD_PACKER_FLUSH_EN
      .clear         (flush_fire),
      .partial_word  (partial_word),
      .partial_valid (partial_valid),
`endif
      .packed_word   (packed_word),
      .last_lane     (last_lane)
   );

   assign out_free = ~m_axis_tvalid | m_axis_tready;

`ifdef AXIS_WORD_PACKER_FLUSH_EN
   assign flush_fire = running & flush & partial_valid & out_free;
`else
   assign flush_fire = 1'b0;
`endif

   // Only the last lane can stall, and only while the output register is full and not draining.
   assign s_axis_tready = running & ~flush_fire & (~last_lane | out_free);
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign load          = accept & last_lane;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         running <= 1'b0;
      end else begin
         running <= 1'b1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
      end else if (load) begin
         m_axis_tdata  <= packed_word;
         m_axis_tvalid <= 1'b1;
      end
`ifdef AXIS_WORD_PACKER_FLUSH_EN
      else if (flush_fire) begin
         m_axis_tdata  <= partial_word;
         m_axis_tvalid <= 1'b1;
      end
`endif
      else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_word_packer.sv
// Self-checking bench for axis_word_packer: directed scenarios plus random traffic against a queue model.
module tb_axis_word_packer;

   localparam int S_W   = 32;
   localparam int M_W   = 128;
   localparam int RATIO = M_W / S_W;
   localparam int CW    = 2;

   logic           aclk = 1'b0;
   logic           areset;
   logic [15:0]    cfg_data;
   logic [S_W-1:0] s_axis_tdata;
   logic           s_axis_tvalid;
   logic           s_axis_tready;
   logic [M_W-1:0] m_axis_tdata;
   logic           m_axis_tvalid;
   logic           m_axis_tready;
   logic           flush;

   int errors = 0;
   int checks = 0;

   // Reference model state: words collected for the open beat and beats awaiting output.
   logic [S_W-1:0] cur_words[$];
   int             beat_n;
   logic [M_W-1:0] exp_q[$];

   axis_word_packer #(
      .S_AXIS_TDATA_WIDTH (S_W),
      .M_AXIS_TDATA_WIDTH (M_W)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_data      (cfg_data),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
`ifdef AXIS_WORD_PACKER_FLUSH_EN
      .flush         (flush),
`endif
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input logic [M_W-1:0] got, input logic [M_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int beatSize(input logic [15:0] cfg);
      int low;
      low = int'(cfg) % (1 << CW);
      return ((low < RATIO - 1) ? low : RATIO - 1) + 1;
   endfunction

   function automatic logic [M_W-1:0] packWords();
      logic [M_W-1:0] beat;
      beat = '0;
      foreach (cur_words[k]) beat = beat | (M_W'(cur_words[k]) << (S_W * k));
      return beat;
   endfunction

   // One clock cycle: drive after the falling edge, check just before the rising edge, advance the model.
   task automatic applyStimulus(input logic v, input logic [S_W-1:0] d, input logic mr,
                                input logic [15:0] cfg, input logic fl, output logic accepted);
      int   n_eff;
      logic next_last;
      logic fl_fire;
      logic exp_ready;
      @(negedge aclk);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      m_axis_tready = mr;
      cfg_data      = cfg;
      flush         = fl;
      #4;
      checkOutput("m_tvalid", M_W'(m_axis_tvalid), M_W'(exp_q.size() != 0));
      if (exp_q.size() != 0) checkOutput("m_tdata", m_axis_tdata, exp_q[0]);
      n_eff     = (cur_words.size() == 0) ? beatSize(cfg) : beat_n;
      next_last = (cur_words.size() == n_eff - 1);
      fl_fire   = fl && (cur_words.size() != 0) && (exp_q.size() == 0 || mr);
      exp_ready = !fl_fire && !(next_last && exp_q.size() != 0 && !mr);
      checkOutput("s_tready", M_W'(s_axis_tready), M_W'(exp_ready));
      accepted = v && exp_ready;
      if (exp_q.size() != 0 && mr) void'(exp_q.pop_front());
      if (fl_fire) begin
         exp_q.push_back(packWords());
         cur_words.delete();
      end else if (accepted) begin
         if (cur_words.size() == 0) beat_n = n_eff;
         cur_words.push_back(d);
         if (cur_words.size() == beat_n) begin
            exp_q.push_back(packWords());
            cur_words.delete();
         end
      end
   endtask

   task automatic doReset();
      @(negedge aclk);
      areset        = 1'b1;
      s_axis_tvalid = 1'b0;
      flush         = 1'b0;
      m_axis_tready = 1'b1;
      #4;
      checkOutput("rst_tvalid", M_W'(m_axis_tvalid), '0);
      checkOutput("rst_tdata", m_axis_tdata, '0);
      checkOutput("rst_tready", M_W'(s_axis_tready), '0);
      @(negedge aclk);
      areset = 1'b0;
      cur_words.delete();
      exp_q.delete();
   endtask

   initial begin
      logic        acc;
      int          n_acc;
      logic [31:0] w;
      logic [15:0] cfg;
      logic        mr;
      areset        = 1'b1;
      cfg_data      = 16'd3;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      flush         = 1'b0;
      beat_n        = 1;
      doReset();

      // Four words into one beat, visible one cycle after the fourth handshake
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b1, 16'd3, 1'b0, acc);
      applyStimulus(1'b0, '0, 1'b1, 16'd3, 1'b0, acc);
      checkOutput("t1_valid", M_W'(m_axis_tvalid), M_W'(1));
      checkOutput("t1_beat", m_axis_tdata, 128'h00000004_00000003_00000002_00000001);

      // Two-word beats with zero upper lanes
      applyStimulus(1'b1, 32'hA, 1'b1, 16'd1, 1'b0, acc);
      applyStimulus(1'b1, 32'hB, 1'b1, 16'd1, 1'b0, acc);
      applyStimulus(1'b1, 32'hC, 1'b1, 16'd1, 1'b0, acc);
      checkOutput("t2_beat0", m_axis_tdata, 128'h00000000_00000000_0000000B_0000000A);
      applyStimulus(1'b1, 32'hD, 1'b1, 16'd1, 1'b0, acc);
      applyStimulus(1'b0, '0, 1'b1, 16'd1, 1'b0, acc);
      checkOutput("t2_beat1", m_axis_tdata, 128'h00000000_00000000_0000000D_0000000C);

      // Output stalled for ten cycles with eight words offered
      n_acc = 0;
      w = 32'h100;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, w, 1'b0, 16'd3, 1'b0, acc);
         if (acc) begin
            n_acc++;
            w++;
         end
      end
      checkOutput("t3_accepted", M_W'(n_acc), M_W'(7));
      for (int i = 0; i < 20 && n_acc < 8; i++) begin
         applyStimulus(1'b1, w, 1'b1, 16'd3, 1'b0, acc);
         if (acc) begin
            n_acc++;
            w++;
         end
      end
      checkOutput("t3_total", M_W'(n_acc), M_W'(8));
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 16'd3, 1'b0, acc);

      // cfg change mid-beat only affects the following beat
      applyStimulus(1'b1, 32'h201, 1'b1, 16'd3, 1'b0, acc);
      applyStimulus(1'b1, 32'h202, 1'b1, 16'd3, 1'b0, acc);
      for (int i = 3; i <= 6; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 16'd1, 1'b0, acc);
      applyStimulus(1'b0, '0, 1'b1, 16'd1, 1'b0, acc);
      checkOutput("t4_beat1", m_axis_tdata, 128'h00000000_00000000_00000206_00000205);

      // Reset in the middle of a beat discards the partial words
      applyStimulus(1'b1, 32'h301, 1'b1, 16'd3, 1'b0, acc);
      applyStimulus(1'b1, 32'h302, 1'b1, 16'd3, 1'b0, acc);
      doReset();
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'h310 + 32'(i), 1'b1, 16'd3, 1'b0, acc);
      applyStimulus(1'b0, '0, 1'b1, 16'd3, 1'b0, acc);
      checkOutput("t5_beat", m_axis_tdata, 128'h00000314_00000313_00000312_00000311);

`ifdef AXIS_WORD_PACKER_FLUSH_EN
      // Flush of a three-word partial beat, then the next word starts at lane 0
      for (int i = 5; i <= 7; i++) applyStimulus(1'b1, 32'(i), 1'b1, 16'd3, 1'b0, acc);
      applyStimulus(1'b1, 32'd8, 1'b1, 16'd3, 1'b1, acc);
      checkOutput("t6_flush_stall", M_W'(acc), '0);
      applyStimulus(1'b1, 32'd8, 1'b1, 16'd3, 1'b0, acc);
      checkOutput("t6_beat", m_axis_tdata, 128'h00000000_00000007_00000006_00000005);
      for (int i = 9; i <= 11; i++) applyStimulus(1'b1, 32'(i), 1'b1, 16'd3, 1'b0, acc);
      applyStimulus(1'b0, '0, 1'b1, 16'd3, 1'b0, acc);
      checkOutput("t6_next", m_axis_tdata, 128'h0000000B_0000000A_00000009_00000008);
`endif

      // Random valid/ready traffic over all cfg values
      cfg = 16'd3;
      mr  = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         logic fl;
         if ($urandom_range(0, 19) == 0) cfg = 16'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) mr = ~mr;
         fl = 1'b0;
`ifdef AXIS_WORD_PACKER_FLUSH_EN
         fl = ($urandom_range(0, 15) == 0);
`endif
         if (i == 2000) doReset();
         applyStimulus($urandom_range(0, 3) != 0, $urandom, mr | ($urandom_range(0, 1) == 1),
                       cfg, fl, acc);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, cfg, 1'b0, acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
